gcd_core: RTL

//  Iterative subtractive-Euclid engine; sits directly downstream of the operand-capture

---
 rtl/gcd_core.sv | 107 ++++++++++
 1 files changed

// File: rtl/gcd_core.sv
// Subtractive-Euclid GCD engine: loads |Ain|/|Bin| on Start, performs one
// compare-subtract per clock, and holds the result and step count until the next Start.
module gcd_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ITER_WIDTH = 32
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic signed [DATA_WIDTH-1:0] Ain,
    input  logic signed [DATA_WIDTH-1:0] Bin,
    output logic        [DATA_WIDTH-1:0] Gcd,
    output logic        [ITER_WIDTH-1:0] Iter,
    output logic                         Busy,
    output logic                         Done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_gcd;
    logic [ITER_WIDTH-1:0] r_iter;
    logic                  w_load;
    logic                  w_step;
    logic                  w_finish;

    // Magnitude as unsigned; the most negative input maps to 2^(DATA_WIDTH-1) exactly.
    function automatic logic [DATA_WIDTH-1:0] abs_u(input logic signed [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] u;
        u = x;
        return x[DATA_WIDTH-1] ? (~u + DATA_WIDTH'(1)) : u;
    endfunction

    function automatic logic [ITER_WIDTH-1:0] sat_inc(input logic [ITER_WIDTH-1:0] v);
        return (&v) ? v : v + ITER_WIDTH'(1);
    endfunction

    always_comb begin
        w_next   = r_state;
        Busy     = 1'b0;
        Done     = 1'b0;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                Done = (r_state == S_DONE);
                if (Start) begin
                    w_load = 1'b1;
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                Busy = 1'b1;
                if ((r_a == '0) || (r_b == '0)) begin
                    w_finish = 1'b1;
                    w_next   = S_DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_gcd  <= '0;
            r_iter <= '0;
        end else if (w_load) begin
            r_a    <= abs_u(Ain);
            r_b    <= abs_u(Bin);
            r_iter <= '0;
        end else if (w_finish) begin
            // One operand is zero here, so OR yields the other.
            r_gcd <= r_a | r_b;
        end else if (w_step) begin
            if (r_a >= r_b) begin
                r_a <= r_a - r_b;
            end else begin
                r_b <= r_b - r_a;
            end
            r_iter <= sat_inc(r_iter);
        end
    end

    assign Gcd  = r_gcd;
    assign Iter = r_iter;

endmodule
